// File: rtl/alu_sequencer.sv
// Command sequencer: buffers {op, operand} commands in a FIFO and drives an
// external 9-bit ALU, retiring one command every two cycles into the accumulator.
module alu_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic [8:0] CMD_DATA,
    output logic [1:0] ALU_SEL,
    output logic [8:0] ALU_AC,
    output logic [8:0] ALU_DR,
    input  logic [8:0] ALU_OUT,
    input  logic       ALU_CARRY,
    output logic [8:0] AC_Q,
    output logic       CARRY_Q,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

    state_t        r_state;
    logic [10:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [8:0]    r_dr;
    logic [8:0]    r_ac;
    logic [1:0]    r_op;
    logic          r_carry;
    logic          r_done;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [10:0]   w_head;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = CMD_VALID && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {CMD_OP, CMD_DATA};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_dr    <= '0;
            r_op    <= '0;
            r_ac    <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (!w_empty) begin
                        r_dr    <= w_head[8:0];
                        r_op    <= w_head[10:9];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_op == OP_LOAD) begin
                        r_ac    <= r_dr;
                        r_carry <= 1'b0;
                    end else begin
                        r_ac    <= ALU_OUT;
                        r_carry <= ALU_CARRY;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = !w_full;
    assign ALU_SEL   = (r_op == OP_LOAD) ? 2'b00 : r_op;
    assign ALU_AC    = r_ac;
    assign ALU_DR    = r_dr;
    assign AC_Q      = r_ac;
    assign CARRY_Q   = r_carry;
    assign BUSY      = (r_state == S_EXEC) || !w_empty;
    assign DONE      = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, command scoreboard with an accumulator
// model, table-driven single commands, directed multi-cycle cases and random traffic.
module tb_alu_sequencer;

    typedef struct {
        logic [1:0] op;
        logic [8:0] data;
    } cmd_t;

    typedef struct {
        logic [1:0] op;
        logic [8:0] data;
        logic [8:0] exp_ac;
        logic       exp_c;
    } vec_t;

    logic       CLK;
    logic       RESET;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_OP;
    logic [8:0] CMD_DATA;
    logic [1:0] ALU_SEL;
    logic [8:0] ALU_AC;
    logic [8:0] ALU_DR;
    logic [8:0] ALU_OUT;
    logic       ALU_CARRY;
    logic [8:0] AC_Q;
    logic       CARRY_Q;
    logic       BUSY;
    logic       DONE;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    cmd_t sb_q[$];
    int m_ac = 0;
    int m_c = 0;

    alu_sequencer #(.FIFO_DEPTH(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_DATA  (CMD_DATA),
        .ALU_SEL   (ALU_SEL),
        .ALU_AC    (ALU_AC),
        .ALU_DR    (ALU_DR),
        .ALU_OUT   (ALU_OUT),
        .ALU_CARRY (ALU_CARRY),
        .AC_Q      (AC_Q),
        .CARRY_Q   (CARRY_Q),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External ALU: bit 9 of the 10-bit result is carry (ADD) or borrow (SUB).
    always_comb begin
        {ALU_CARRY, ALU_OUT} = 10'd0;
        case (ALU_SEL)
            2'b00:   {ALU_CARRY, ALU_OUT} = {1'b0, ALU_AC} + {1'b0, ALU_DR};
            2'b01:   {ALU_CARRY, ALU_OUT} = {1'b0, ALU_AC} - {1'b0, ALU_DR};
            2'b10:   {ALU_CARRY, ALU_OUT} = {1'b0, ALU_AC & ALU_DR};
            default: {ALU_CARRY, ALU_OUT} = 10'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        if (!RESET && CMD_VALID && CMD_READY) begin
            sb_q.push_back('{op: CMD_OP, data: CMD_DATA});
        end
    end

    always @(negedge CLK) begin
        if (!RESET && DONE) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("done_without_command", 32'(sb_q.size()), 32'd1);
            end else begin
                cmd_t c;
                int d;
                c = sb_q.pop_front();
                d = int'(c.data);
                case (c.op)
                    2'b00: begin m_c = ((m_ac + d) > 511) ? 1 : 0; m_ac = (m_ac + d) % 512; end
                    2'b01: begin m_c = (m_ac < d) ? 1 : 0; m_ac = (m_ac - d + 512) % 512; end
                    2'b10: begin m_c = 0; m_ac = m_ac & d; end
                    default: begin m_c = 0; m_ac = d; end
                endcase
                chk("sb_ac", 32'(AC_Q), 32'(m_ac));
                chk("sb_carry", 32'(CARRY_Q), 32'(m_c));
                chk("sb_alu_ac", 32'(ALU_AC), 32'(m_ac));
            end
        end
    end

    // Called mid-cycle; raises reset between edges and checks the immediate effect.
    task automatic reset_pulse(input string name);
        #2;
        RESET = 1'b1;
        CMD_VALID = 1'b0;
        sb_q.delete();
        m_ac = 0;
        m_c = 0;
        #1;
        chk({name, "_ac"}, 32'(AC_Q), 32'd0);
        chk({name, "_carry"}, 32'(CARRY_Q), 32'd0);
        chk({name, "_done"}, 32'(DONE), 32'd0);
        chk({name, "_busy"}, 32'(BUSY), 32'd0);
        chk({name, "_ready"}, 32'(CMD_READY), 32'd1);
        chk({name, "_sel"}, 32'(ALU_SEL), 32'd0);
        chk({name, "_dr"}, 32'(ALU_DR), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic send_one(input logic [1:0] op, input logic [8:0] d,
                            input logic [8:0] ea, input logic ec, input string name);
        logic [1:0] esel;
        esel = (op == 2'b11) ? 2'b00 : op;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP = op;
        CMD_DATA = d;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        chk({name, "_n_busy"}, 32'(BUSY), 32'd1);
        chk({name, "_n_done"}, 32'(DONE), 32'd0);
        @(posedge CLK);
        #1;
        chk({name, "_n1_dr"}, 32'(ALU_DR), 32'(d));
        chk({name, "_n1_sel"}, 32'(ALU_SEL), 32'(esel));
        chk({name, "_n1_done"}, 32'(DONE), 32'd0);
        @(posedge CLK);
        #1;
        chk({name, "_n2_done"}, 32'(DONE), 32'd1);
        chk({name, "_n2_ac"}, 32'(AC_Q), 32'(ea));
        chk({name, "_n2_carry"}, 32'(CARRY_Q), 32'(ec));
        chk({name, "_n2_busy"}, 32'(BUSY), 32'd0);
        @(posedge CLK);
        #1;
        chk({name, "_n3_done"}, 32'(DONE), 32'd0);
    endtask

    // Holds CMD_VALID high across the list; first_low = commands accepted when READY first fell.
    task automatic burst(input cmd_t cmds[$], output int first_low);
        int idx;
        int cyc;
        logic rdy;
        idx = 0;
        cyc = 0;
        first_low = -1;
        while (idx < cmds.size() && cyc < 200) begin
            @(negedge CLK);
            CMD_VALID = 1'b1;
            CMD_OP = cmds[idx].op;
            CMD_DATA = cmds[idx].data;
            rdy = CMD_READY;
            if (!rdy && first_low < 0) first_low = idx;
            @(posedge CLK);
            if (rdy) idx++;
            cyc++;
        end
        if (cyc >= 200) chk("burst_timeout", 32'(idx), 32'(cmds.size()));
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge CLK);
            #1;
            cyc++;
        end while ((BUSY || sb_q.size() != 0) && cyc < 200);
        chk({name, "_idle_busy"}, 32'(BUSY), 32'd0);
        chk({name, "_idle_pending"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        cmd_t cl[$];
        int first_low;
        int d0;

        vecs[0] = '{op: 2'b11, data: 9'h1FF, exp_ac: 9'h1FF, exp_c: 1'b0};
        vecs[1] = '{op: 2'b00, data: 9'h001, exp_ac: 9'h000, exp_c: 1'b1};
        vecs[2] = '{op: 2'b11, data: 9'h005, exp_ac: 9'h005, exp_c: 1'b0};
        vecs[3] = '{op: 2'b01, data: 9'h007, exp_ac: 9'h1FE, exp_c: 1'b1};
        vecs[4] = '{op: 2'b11, data: 9'h0F3, exp_ac: 9'h0F3, exp_c: 1'b0};
        vecs[5] = '{op: 2'b10, data: 9'h13C, exp_ac: 9'h030, exp_c: 1'b0};
        vecs[6] = '{op: 2'b11, data: 9'h100, exp_ac: 9'h100, exp_c: 1'b0};
        vecs[7] = '{op: 2'b00, data: 9'h0FF, exp_ac: 9'h1FF, exp_c: 1'b0};
        vecs[8] = '{op: 2'b01, data: 9'h1FF, exp_ac: 9'h000, exp_c: 1'b0};
        vecs[9] = '{op: 2'b00, data: 9'h000, exp_ac: 9'h000, exp_c: 1'b0};

        RESET = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP = 2'b00;
        CMD_DATA = 9'h000;
        repeat (2) @(negedge CLK);
        chk("rst_hold_ready", 32'(CMD_READY), 32'd1);
        chk("rst_hold_sel", 32'(ALU_SEL), 32'd0);
        RESET = 1'b0;
        #1;
        chk("rst_ac", 32'(AC_Q), 32'd0);
        chk("rst_carry", 32'(CARRY_Q), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ready", 32'(CMD_READY), 32'd1);

        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i].op, vecs[i].data, vecs[i].exp_ac, vecs[i].exp_c, $sformatf("vec%0d", i));
        end

        send_one(2'b11, 9'h155, 9'h155, 1'b0, "preload");
        @(negedge CLK);
        reset_pulse("async_rst");

        // Six back-to-back commands never fill a 4-deep FIFO draining at one per two cycles.
        d0 = done_cnt;
        cl.delete();
        cl.push_back('{op: 2'b11, data: 9'h000});
        for (int i = 0; i < 5; i++) cl.push_back('{op: 2'b00, data: 9'h001});
        burst(cl, first_low);
        wait_idle("bp6");
        chk("bp6_done_count", 32'(done_cnt - d0), 32'd6);
        chk("bp6_ac", 32'(AC_Q), 32'h005);
        chk("bp6_busy", 32'(BUSY), 32'd0);

        d0 = done_cnt;
        cl.delete();
        cl.push_back('{op: 2'b11, data: 9'h000});
        for (int i = 0; i < 9; i++) cl.push_back('{op: 2'b00, data: 9'h001});
        burst(cl, first_low);
        chk("bp10_ready_drop_at", 32'(first_low), 32'd7);
        wait_idle("bp10");
        chk("bp10_done_count", 32'(done_cnt - d0), 32'd10);
        chk("bp10_ac", 32'(AC_Q), 32'h009);

        // Push coincides with pop at the 4th edge (count 2); last DONE edge fixes BUSY fall.
        d0 = done_cnt;
        cl.delete();
        cl.push_back('{op: 2'b11, data: 9'h1A0});
        cl.push_back('{op: 2'b00, data: 9'h0C0});
        cl.push_back('{op: 2'b01, data: 9'h011});
        cl.push_back('{op: 2'b10, data: 9'h0F0});
        burst(cl, first_low);
        repeat (4) @(posedge CLK);
        #1;
        chk("pushpop_busy_e8", 32'(BUSY), 32'd1);
        @(posedge CLK);
        #1;
        chk("pushpop_busy_e9", 32'(BUSY), 32'd0);
        wait_idle("pushpop");
        chk("pushpop_done_count", 32'(done_cnt - d0), 32'd4);
        chk("pushpop_ac", 32'(AC_Q), 32'h040);
        chk("pushpop_carry", 32'(CARRY_Q), 32'd0);

        // After the 6th push edge the sequencer is in EXEC with three entries queued.
        cl.delete();
        cl.push_back('{op: 2'b11, data: 9'h011});
        for (int i = 1; i <= 5; i++) cl.push_back('{op: 2'b00, data: 9'(i)});
        burst(cl, first_low);
        chk("midrst_busy_before", 32'(BUSY), 32'd1);
        d0 = done_cnt;
        reset_pulse("midrst");
        repeat (5) @(negedge CLK);
        #1;
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_ac", 32'(AC_Q), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        send_one(2'b11, 9'h0AA, 9'h0AA, 1'b0, "post_rst_load");

        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 149) == 0) begin
                reset_pulse("rand_rst");
            end else begin
                CMD_VALID = ($urandom_range(0, 2) != 0);
                CMD_OP = 2'($urandom_range(0, 3));
                CMD_DATA = 9'($urandom_range(0, 511));
            end
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
        wait_idle("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entry count; SHALL be a power of two, 2 or greater.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 CMD_VALID  input  1  command present on CMD_OP/CMD_DATA.
REQ-005 CMD_READY  output  1  FIFO can accept a command this cycle.
REQ-006 CMD_OP  input  2  00 ADD, 01 SUB, 10 AND, 11 LOAD (AC takes CMD_DATA).
REQ-007 CMD_DATA  input  9  operand.
REQ-008 ALU_SEL  output  2  ALU operation select.
REQ-009 ALU_AC  output  9  ALU A operand, equal to AC_Q.
REQ-010 ALU_DR  output  9  ALU B operand, equal to the internal DR register.
REQ-011 ALU_OUT  input  9  ALU result.
REQ-012 ALU_CARRY  input  1  ALU bit 9: carry for ADD, borrow for SUB, 0 for AND.
REQ-013 AC_Q  output  9  accumulator.
REQ-014 CARRY_Q  output  1  carry/borrow flag.
REQ-015 BUSY  output  1  high while state is EXEC or the FIFO is non-empty.
REQ-016 DONE  output  1  one-cycle pulse, one per completed command.

Function
REQ-017 Command transfer SHALL occur when CMD_VALID && CMD_READY at a rising edge; CMD_OP and CMD_DATA are pushed as one FIFO entry.
REQ-018 CMD_READY SHALL be low exactly when the FIFO count equals FIFO_DEPTH; it SHALL NOT combinationally depend on a same-cycle pop.
REQ-019 Push and pop in the same cycle SHALL leave the count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 CMD_VALID while CMD_READY is low SHALL be ignored; no FIFO state changes.
REQ-021 The FSM SHALL have two states: IDLE and EXEC.
REQ-022 IDLE, FIFO non-empty: at the edge, pop the head, DR <= entry data, OP register <= entry op, go to EXEC.
REQ-023 IDLE, FIFO empty: stay in IDLE; DR and the OP register hold their values.
REQ-024 EXEC, ops 00/01/10: at the edge, AC_Q <= ALU_OUT and CARRY_Q <= ALU_CARRY.
REQ-025 EXEC, op 11: at the edge, AC_Q <= DR and CARRY_Q <= 0.
REQ-026 EXEC: state SHALL always go to IDLE at the edge, and DONE SHALL be high for the following cycle only.
REQ-027 ALU_SEL SHALL be driven from the OP register for ops 00/01/10, and 2'b00 for op 11.
REQ-028 Throughput SHALL be one command per 2 cycles.
REQ-029 Latency: command pushed into an empty FIFO while IDLE at edge N gives a pop at edge N+1, AC_Q update at edge N+2, and DONE high in the cycle after edge N+2.
REQ-030 Arithmetic SHALL be 9-bit modulo 2^9; overflow appears only on CARRY_Q.
REQ-031 Commands SHALL execute strictly in acceptance order; none are dropped or duplicated.

Reset
REQ-032 RESET high SHALL immediately force state IDLE, FIFO count 0, both pointers 0, AC_Q 0, DR 0, OP register 0, CARRY_Q 0, DONE 0 and BUSY 0.
REQ-033 While RESET is high, CMD_READY SHALL be 1 and ALU_SEL SHALL be 00.
REQ-034 RESET asserted mid-EXEC or with the FIFO occupied SHALL discard all pending and in-flight commands with no DONE pulse.
REQ-035 After RESET deasserts, the first command SHALL follow the REQ-029 timing.

Verification
REQ-036 Reset check: assert RESET asynchronously between edges -> all outputs 0 at once, CMD_READY 1.
REQ-037 ADD with carry: LOAD 0x1FF, then ADD 0x001 -> AC_Q 0x000, CARRY_Q 1, two DONE pulses, REQ-029 timing met.
REQ-038 SUB with borrow, then AND: LOAD 0x005, SUB 0x007 -> AC_Q 0x1FE, CARRY_Q 1; then LOAD 0x0F3, AND 0x13C -> AC_Q 0x030, CARRY_Q 0.
REQ-039 Backpressure: CMD_VALID held high for LOAD 0x000 plus five ADD 0x001 commands.
- CMD_READY drops when the count reaches 4.
- All six commands complete in order with six DONE pulses.
- Final AC_Q is 0x005; BUSY is 0 afterwards.
REQ-040 Reset mid-operation: assert RESET while in EXEC with 3 entries queued -> no DONE pulse, AC_Q 0, BUSY 0; a following LOAD 0x0AA completes with AC_Q 0x0AA.
REQ-041 Simultaneous push and pop: push on the exact edge the FIFO pops (count 2) -> count stays 2, no entry lost; run past a pointer wrap and confirm order is preserved.
